// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the two-master picorv32 bus arbiter: FSM encodings,
// default error response, and the SoC decode map that the arbiter fronts.
package mem_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_GNT0 = 2'b01,
        ARB_GNT1 = 2'b10
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int unsigned TIMEOUT_DEFAULT   = 32'd64;

    // SoC slave map decoded downstream of the arbiter
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] ROM_BASE  = 32'h0001_0000;
    localparam logic [31:0] MMUP_BASE = 32'h0010_0000;

    // One-hot owner vector for a given arbiter state
    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ARB_GNT0: g = 2'b01;
            ARB_GNT1: g = 2'b10;
            default:  g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter2_if.sv
// One picorv32 native memory bus port. The requester uses the master modport,
// the responder uses the slave modport.
interface mem_arbiter2_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/mem_arbiter2_watchdog.sv
// Bus watchdog: counts stalled cycles of the current transfer and flags the
// cycle in which the stall budget runs out. TIMEOUT of 0 never expires.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 32'd64
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    input  logic stall,
    output logic expire
);
    localparam logic [31:0] LIMIT = (TIMEOUT == 32'd0) ? 32'd0 : 32'(TIMEOUT - 32'd1);

    logic [31:0] wd_cnt_r;

    // Stall counter, saturating so a disabled watchdog cannot wrap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_r <= 32'd0;
        end else if (clr) begin
            wd_cnt_r <= 32'd0;
        end else if (en && stall && (wd_cnt_r != 32'hFFFF_FFFF)) begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Expiry is evaluated in the stalled cycle itself so the forced completion lands on it
    always_comb begin
        expire = 1'b0;
        if ((TIMEOUT != 32'd0) && en && stall && (wd_cnt_r == LIMIT)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin two-master arbiter for the picorv32 native bus,
// holding the grant until the transfer completes or the watchdog forces an error.
module mem_arbiter2
    import mem_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic           clk,
    input  logic           resetn,
    mem_arbiter2_if.slave  m0,
    mem_arbiter2_if.slave  m1,
    mem_arbiter2_if.master s,
    output logic [1:0]     grant,
    output logic           bus_err,
    output logic [31:0]    err_addr
);

    arb_state_e  state_r;
    arb_state_e  state_s;
    logic        last_r;        // 1'b0: M0 granted most recently, 1'b1: M1
    logic        bus_err_r;
    logic [31:0] err_addr_r;

    logic        cur_valid_s;
    logic        cur_instr_s;
    logic [31:0] cur_addr_s;
    logic [31:0] cur_wdata_s;
    logic [3:0]  cur_wstrb_s;
    logic        done_s;
    logic [31:0] rsp_rdata_s;
    logic        wd_clr_s;
    logic        wd_en_s;
    logic        wd_expire_s;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .resetn (resetn),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .stall  (!s.ready),
        .expire (wd_expire_s)
    );

    // Arbiter state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Round-robin pointer, starts at M1 so M0 wins the first tie
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_r <= 1'b1;
        end else if ((state_r == ARB_IDLE) && (state_s == ARB_GNT0)) begin
            last_r <= 1'b0;
        end else if ((state_r == ARB_IDLE) && (state_s == ARB_GNT1)) begin
            last_r <= 1'b1;
        end else begin
            last_r <= last_r;
        end
    end

    // Error pulse and address of the last forced completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= 32'd0;
        end else if (wd_expire_s) begin
            bus_err_r  <= 1'b1;
            err_addr_r <= cur_addr_s;
        end else begin
            bus_err_r  <= 1'b0;
            err_addr_r <= err_addr_r;
        end
    end

    // Select the owning master's request
    always_comb begin
        cur_valid_s = 1'b0;
        cur_instr_s = 1'b0;
        cur_addr_s  = 32'd0;
        cur_wdata_s = 32'd0;
        cur_wstrb_s = 4'd0;
        case (state_r)
            ARB_GNT0: begin
                cur_valid_s = m0.valid;
                cur_instr_s = m0.instr;
                cur_addr_s  = m0.addr;
                cur_wdata_s = m0.wdata;
                cur_wstrb_s = m0.wstrb;
            end
            ARB_GNT1: begin
                cur_valid_s = m1.valid;
                cur_instr_s = m1.instr;
                cur_addr_s  = m1.addr;
                cur_wdata_s = m1.wdata;
                cur_wstrb_s = m1.wstrb;
            end
            default: begin
                cur_valid_s = 1'b0;
            end
        endcase
    end

    // Slave request, watchdog controls and routed responses
    always_comb begin
        wd_clr_s    = (state_r == ARB_IDLE);
        wd_en_s     = (state_r != ARB_IDLE) && cur_valid_s;
        // A dropped valid while granted ends the transfer silently
        done_s      = cur_valid_s && (s.ready || wd_expire_s);
        rsp_rdata_s = wd_expire_s ? ERR_RDATA : s.rdata;

        s.valid = cur_valid_s && !wd_expire_s;
        s.instr = cur_instr_s;
        s.addr  = cur_addr_s;
        s.wdata = cur_wdata_s;
        s.wstrb = cur_wstrb_s;

        m0.ready = 1'b0;
        m0.rdata = 32'd0;
        m1.ready = 1'b0;
        m1.rdata = 32'd0;
        if (state_r == ARB_GNT0) begin
            m0.ready = done_s;
            m0.rdata = rsp_rdata_s;
        end else if (state_r == ARB_GNT1) begin
            m1.ready = done_s;
            m1.rdata = rsp_rdata_s;
        end else begin
            m0.ready = 1'b0;
            m1.ready = 1'b0;
        end
    end

    // Next-state: grant on request, release after completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (m0.valid && m1.valid) begin
                    state_s = last_r ? ARB_GNT0 : ARB_GNT1;
                end else if (m0.valid) begin
                    state_s = ARB_GNT0;
                end else if (m1.valid) begin
                    state_s = ARB_GNT1;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_GNT0, ARB_GNT1: begin
                if (!cur_valid_s || done_s) begin
                    state_s = ARB_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    assign grant    = grant_of(state_r);
    assign bus_err  = bus_err_r;
    assign err_addr = err_addr_r;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Scoreboard bench for mem_arbiter2: expected read data is queued per master
// as requests are issued and compared when the arbiter signals ready.
module tb_mem_arbiter2;

    localparam logic [31:0] K    = 32'h1234_5678;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter2_if m0_a ();
    mem_arbiter2_if m1_a ();
    mem_arbiter2_if s_a ();
    mem_arbiter2_if m0_b ();
    mem_arbiter2_if m1_b ();
    mem_arbiter2_if s_b ();

    logic [1:0]  grant_a, grant_b;
    logic        bus_err_a, bus_err_b;
    logic [31:0] err_addr_a, err_addr_b;

    mem_arbiter2 #(.TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .m0(m0_a), .m1(m1_a), .s(s_a),
        .grant(grant_a), .bus_err(bus_err_a), .err_addr(err_addr_a)
    );

    mem_arbiter2 #(.TIMEOUT(0)) dut_nowd (
        .clk(clk), .resetn(resetn), .m0(m0_b), .m1(m1_b), .s(s_b),
        .grant(grant_b), .bus_err(bus_err_b), .err_addr(err_addr_b)
    );

    int checks = 0;
    int errors = 0;

    req_t        rq0[$];
    req_t        rq1[$];
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          done_ids[$];

    bit hang_a = 1'b0;
    int lat_a  = 1;
    int gcnt_a = 0;

    int   cyc = 0;
    int   ready_cyc = 0;
    int   ready_g = 0;
    logic ready_sv = 1'b0;
    int   err_cyc = 0;
    int   err_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_ids.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("done_count", done_ids.size(), n);
    endtask

    task automatic wait_grant(input logic [1:0] g, input int budget);
        int k = 0;
        while (grant_a !== g && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_grant", {30'd0, grant_a}, {30'd0, g});
    endtask

    // Slave model for dut: ready after lat_a grant cycles unless hung
    initial begin
        s_a.ready = 1'b0;
        s_a.rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (grant_a != 2'b00) gcnt_a++;
            else gcnt_a = 0;
            s_a.ready = !hang_a && (gcnt_a == lat_a + 1);
            s_a.rdata = (gcnt_a != 0) ? (s_a.addr ^ K) : 32'd0;
        end
    end

    // Master models: hold request until ready, then issue the next queued one
    initial begin
        logic d0, d1;
        req_t r;
        m0_a.valid = 1'b0; m0_a.instr = 1'b0; m0_a.addr = 32'd0; m0_a.wdata = 32'd0; m0_a.wstrb = 4'd0;
        m1_a.valid = 1'b0; m1_a.instr = 1'b0; m1_a.addr = 32'd0; m1_a.wdata = 32'd0; m1_a.wstrb = 4'd0;
        forever begin
            @(negedge clk);
            d0 = m0_a.ready;
            d1 = m1_a.ready;
            @(posedge clk);
            #1;
            if (d0) m0_a.valid = 1'b0;
            if (d1) m1_a.valid = 1'b0;
            if (!m0_a.valid && rq0.size() > 0) begin
                r = rq0.pop_front();
                m0_a.valid = 1'b1; m0_a.instr = r.instr; m0_a.addr = r.addr;
                m0_a.wdata = r.wdata; m0_a.wstrb = r.wstrb;
                exp0.push_back(hang_a ? ERRD : (r.addr ^ K));
            end
            if (!m1_a.valid && rq1.size() > 0) begin
                r = rq1.pop_front();
                m1_a.valid = 1'b1; m1_a.instr = r.instr; m1_a.addr = r.addr;
                m1_a.wdata = r.wdata; m1_a.wstrb = r.wstrb;
                exp1.push_back(hang_a ? ERRD : (r.addr ^ K));
            end
        end
    end

    // Monitor: scoreboard compare on every ready, idle-bus checks every cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (m0_a.ready) begin
                done_ids.push_back(0);
                ready_cyc = cyc; ready_g = gcnt_a; ready_sv = s_a.valid;
                check("m0_exp_pending", {31'd0, exp0.size() > 0}, 32'd1);
                if (exp0.size() > 0) check("m0_rdata", m0_a.rdata, exp0.pop_front());
                check("m1_quiet_ready", {31'd0, m1_a.ready}, 32'd0);
                check("m1_quiet_rdata", m1_a.rdata, 32'd0);
            end
            if (m1_a.ready) begin
                done_ids.push_back(1);
                ready_cyc = cyc; ready_g = gcnt_a; ready_sv = s_a.valid;
                check("m1_exp_pending", {31'd0, exp1.size() > 0}, 32'd1);
                if (exp1.size() > 0) check("m1_rdata", m1_a.rdata, exp1.pop_front());
                check("m0_quiet_rdata", m0_a.rdata, 32'd0);
            end
            if (grant_a == 2'b00) begin
                check("idle_s_valid", {31'd0, s_a.valid}, 32'd0);
                check("idle_ready", {30'd0, m0_a.ready, m1_a.ready}, 32'd0);
            end
            if (bus_err_a) begin
                err_pulses++;
                err_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        int e0;
        int gb;
        int rdy_g;
        int rdy_n;
        int berr_n;
        logic [31:0] rdy_data;
        m0_b.valid = 1'b0; m0_b.instr = 1'b0; m0_b.addr = 32'd0; m0_b.wdata = 32'd0; m0_b.wstrb = 4'd0;
        m1_b.valid = 1'b0; m1_b.instr = 1'b0; m1_b.addr = 32'd0; m1_b.wdata = 32'd0; m1_b.wstrb = 4'd0;
        s_b.ready = 1'b0; s_b.rdata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grant", {30'd0, grant_a}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err_a}, 32'd0);
        check("rst_err_addr", err_addr_a, 32'd0);
        check("rst_s_addr", s_a.addr, 32'd0);

        // M0 instruction fetch, 1-cycle slave
        resetn = 1'b1;
        rq0.push_back('{1'b1, 32'h0000_0000, 32'd0, 4'd0});
        @(negedge clk);
        check("t1_req_grant", {30'd0, grant_a}, 32'd0);
        check("t1_req_s_valid", {31'd0, s_a.valid}, 32'd0);
        @(negedge clk);
        check("t1_grant", {30'd0, grant_a}, 32'd1);
        check("t1_s_valid", {31'd0, s_a.valid}, 32'd1);
        check("t1_s_instr", {31'd0, s_a.instr}, 32'd1);
        check("t1_no_ready_yet", {31'd0, m0_a.ready}, 32'd0);
        wait_done(1, 6);
        check("t1_ready_gcnt", ready_g, 32'd2);
        @(negedge clk);
        check("t1_grant_after", {30'd0, grant_a}, 32'd0);

        // Both masters from reset, held high: alternation 0,1,0,1
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        done_ids.delete();
        rq0.push_back('{1'b0, 32'h0000_0100, 32'd0, 4'd0});
        rq0.push_back('{1'b0, 32'h0000_0104, 32'd0, 4'd0});
        rq1.push_back('{1'b0, 32'h0000_0200, 32'd0, 4'd0});
        rq1.push_back('{1'b0, 32'h0000_0204, 32'd0, 4'd0});
        wait_done(4, 40);
        for (int i = 0; i < 4; i++) begin
            if (i < done_ids.size()) check("t2_alt_order", done_ids[i], i % 2);
        end

        // M1 write, 2-cycle slave, zero-latency ready
        @(negedge clk);
        done_ids.delete();
        lat_a = 2;
        rq1.push_back('{1'b0, 32'h0010_0000, 32'h0000_00A5, 4'b0001});
        wait_grant(2'b10, 10);
        check("t3_s_addr", s_a.addr, 32'h0010_0000);
        check("t3_s_wdata", s_a.wdata, 32'h0000_00A5);
        check("t3_s_wstrb", {28'd0, s_a.wstrb}, 32'd1);
        check("t3_s_instr", {31'd0, s_a.instr}, 32'd0);
        check("t3_ready_low", {31'd0, m1_a.ready}, {31'd0, s_a.ready});
        e0 = 0;
        while (!s_a.ready && e0 < 10) begin
            @(negedge clk);
            e0++;
        end
        check("t3_s_ready_seen", {31'd0, s_a.ready}, 32'd1);
        check("t3_ready_follow", {31'd0, m1_a.ready}, {31'd0, s_a.ready});
        check("t3_rdata_follow", m1_a.rdata, s_a.rdata);
        wait_done(1, 6);

        // Watchdog expiry after 8 stalled grant cycles
        @(negedge clk);
        done_ids.delete();
        hang_a = 1'b1;
        e0 = err_pulses;
        rq0.push_back('{1'b0, 32'h0002_0040, 32'd0, 4'd0});
        wait_done(1, 20);
        check("t4_ready_gcnt", ready_g, 32'd8);
        check("t4_s_valid_dropped", {31'd0, ready_sv}, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_err_pulses", err_pulses - e0, 32'd1);
        check("t4_err_timing", err_cyc, ready_cyc + 1);
        check("t4_err_addr", err_addr_a, 32'h0002_0040);

        // Slave ready exactly at threshold: normal completion
        done_ids.delete();
        hang_a = 1'b0;
        lat_a = 7;
        e0 = err_pulses;
        rq0.push_back('{1'b0, 32'h0002_0080, 32'd0, 4'd0});
        wait_done(1, 20);
        check("t4b_ready_gcnt", ready_g, 32'd8);
        check("t4b_s_valid", {31'd0, ready_sv}, 32'd1);
        repeat (3) @(negedge clk);
        check("t4b_no_err", err_pulses - e0, 32'd0);
        check("t4b_err_addr_hold", err_addr_a, 32'h0002_0040);

        // Reset in the middle of an M1 transfer
        done_ids.delete();
        hang_a = 1'b1;
        lat_a = 1;
        rq1.push_back('{1'b1, 32'h0003_0000, 32'h1111_2222, 4'b1111});
        wait_grant(2'b10, 10);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_grant", {30'd0, grant_a}, 32'd0);
        check("t5_s_valid", {31'd0, s_a.valid}, 32'd0);
        check("t5_s_addr", s_a.addr, 32'd0);
        check("t5_s_wdata", s_a.wdata, 32'd0);
        check("t5_s_wstrb", {28'd0, s_a.wstrb}, 32'd0);
        check("t5_m1_rdata", m1_a.rdata, 32'd0);
        check("t5_err_addr", err_addr_a, 32'd0);
        m0_a.valid = 1'b0;
        m1_a.valid = 1'b0;
        rq0.delete(); rq1.delete(); exp0.delete(); exp1.delete();
        hang_a = 1'b0;
        repeat (2) @(negedge clk);
        done_ids.delete();
        resetn = 1'b1;
        rq0.push_back('{1'b0, 32'h0000_0300, 32'd0, 4'd0});
        rq1.push_back('{1'b0, 32'h0000_0400, 32'd0, 4'd0});
        wait_done(2, 20);
        if (done_ids.size() >= 2) begin
            check("t5_first_m0", done_ids[0], 32'd0);
            check("t5_then_m1", done_ids[1], 32'd1);
        end

        // Watchdog disabled: 200-cycle slave stall completes normally
        @(negedge clk);
        m0_b.valid = 1'b1;
        m0_b.addr  = 32'h0004_0000;
        gb = 0; rdy_g = 0; rdy_n = 0; berr_n = 0; rdy_data = 32'd0;
        for (int c = 0; c < 260; c++) begin
            @(posedge clk);
            #1;
            if (rdy_n > 0) m0_b.valid = 1'b0;
            if (grant_b != 2'b00) gb++;
            else gb = 0;
            s_b.ready = (gb == 200);
            s_b.rdata = (gb == 200) ? 32'h0BAD_F00D : 32'd0;
            @(negedge clk);
            if (m0_b.ready) begin
                rdy_n++;
                rdy_g = gb;
                rdy_data = m0_b.rdata;
            end
            if (bus_err_b) berr_n++;
        end
        check("t6_ready_count", rdy_n, 32'd1);
        check("t6_ready_cycle", rdy_g, 32'd200);
        check("t6_rdata", rdy_data, 32'h0BAD_F00D);
        check("t6_no_bus_err", berr_n, 32'd0);
        check("t6_err_addr", err_addr_b, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master arbiter for the picorv32 native memory bus. It shares the single SoC slave bus (RAM, program ROM and MMUP decode) between the CPU, master 0, and a secondary bus master, master 1, such as a DMA or debug loader. Arbitration is round-robin and holds the grant until the transfer completes. A bus-timeout watchdog completes hung transfers with an error response so neither master can stall the system. It sits between the masters and the existing address decoder / ready mux.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles the arbiter waits for `s_ready` before forcing an error completion. 0 disables the watchdog.
- `ERR_RDATA`, 32'hDEAD_BEEF: read data returned on a timeout completion.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `m0_valid`, `m0_instr`  in  1 each  CPU request and instruction-fetch flag.
- `m0_addr`, `m0_wdata`  in  32 each  CPU address and write data.
- `m0_wstrb`  in  4  CPU byte write strobes; 0 means read.
- `m0_ready`  out  1  CPU transfer complete.
- `m0_rdata`  out  32  CPU read data.
- `m1_valid`, `m1_instr`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_ready`, `m1_rdata`: same widths and meaning for master 1.
- `s_valid`, `s_instr`  out  1 each  request to the slave bus.
- `s_addr`, `s_wdata`  out  32 each  slave bus address and write data.
- `s_wstrb`  out  4  slave bus byte write strobes.
- `s_ready`  in  1  slave transfer complete.
- `s_rdata`  in  32  slave read data.
- `grant`  out  2  one-hot current owner: 01 is M0, 10 is M1, 00 is idle.
- `bus_err`  out  1  one-cycle pulse on a timeout completion.
- `err_addr`  out  32  address of the last timed-out transfer.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`. A round-robin pointer `last` holds the most recently granted master.
- In `IDLE`:
  - only one `mX_valid` high: next state `GNTX`.
  - both high: grant the master that is not `last`.
  - neither high: stay in `IDLE`.
- On entering `GNTX`, `last` updates to X.
- In `GNTX`:
  - `s_valid`, `s_instr`, `s_addr`, `s_wdata`, `s_wstrb` are combinational copies of master X's request.
  - `mX_ready` = `s_ready`; `mX_rdata` = `s_rdata`.
  - The other master sees ready=0 and rdata=0.
- The transfer ends on `s_ready` or on a timeout completion. Next state is `IDLE`.
- In `IDLE`, all `s_*` outputs are 0 and both `mX_ready` are 0.
- Masters follow the picorv32 rule: request fields stay stable and valid stays high until ready. If `mX_valid` drops while granted (protocol violation), return to `IDLE` with no ready and no error.
- Watchdog:
  - `wd_cnt` clears in `IDLE` and counts each `GNTX` cycle with `s_ready`=0.
  - If `TIMEOUT`≠0 and `wd_cnt`==`TIMEOUT-1` with `s_ready`=0, force `mX_ready`=1 and `mX_rdata`=`ERR_RDATA`, deassert `s_valid` that cycle, pulse `bus_err`, and register `err_addr`←`s_addr`.
  - If `s_ready` arrives in the same cycle as the timeout threshold, it is a normal completion and no error is raised.
- Write data passes through unchanged. The arbiter never modifies `wstrb`.

## Timing
- Reset (asynchronous, any time, including mid-transfer): state `IDLE`, `last`=M1 so M0 wins the first tie, `wd_cnt`=0, `bus_err`=0, `err_addr`=0, `grant`=00.
  - All `s_*` and `mX_ready`/`mX_rdata` outputs are 0 while reset is low.
  - An in-flight transfer is abandoned.
- Arbitration latency is 1 cycle: a request seen in `IDLE` at edge n drives `s_valid` from cycle n+1.
- `s_ready`→`mX_ready` has zero latency (combinational).
- There is one `IDLE` bubble cycle between consecutive transfers. A 1-cycle slave gives 3 cycles per transfer as seen by a master: request, grant, then the ready cycle. Sustained throughput is one transfer per 2 cycles plus slave latency.
- A timeout completion occurs exactly `TIMEOUT` cycles after the first `s_valid` cycle.
- `bus_err` is registered and high for exactly one cycle, in the cycle after the forced ready.
- `err_addr` holds its value until the next timeout.

## Structure
- Shared header `bus_defs.vh` holds:
  - the state encodings `ARB_IDLE`, `ARB_GNT0`, `ARB_GNT1`;
  - the default `ERR_RDATA`;
  - the MMUP base addresses already used by the SoC.
- One natural sub-module, `bus_watchdog`: counter plus threshold compare, with inputs `clk`, `resetn`, `clr`, `en`, `stall` and output `expire`.
- The FSM, the pointer and the muxes stay in `mem_arbiter2`.
- Instantiate `mem_arbiter2` in the SoC top between `cpu`/DMA and the existing decode logic.

## Test plan
- M0 read only, slave ready 1 cycle after `s_valid`, `s_rdata`=32'h1234_5678: `m0_ready` pulses once with that data; `grant` goes 01 then 00; `m1_ready` stays 0.
- M0 and M1 both request from reset: M0 is granted first, then M1 after the `IDLE` bubble. With both held high continuously, grants alternate 01,10,01,10.
- M1 write, `addr`=32'h0010_0000, `wdata`=32'hA5, `wstrb`=4'b0001: `s_*` shows the same values; `m1_ready` follows `s_ready` in the same cycle.
- `TIMEOUT`=8, slave never readies: `m0_ready`=1 with rdata 32'hDEAD_BEEF 8 cycles after the first `s_valid`; `bus_err` pulses once; `err_addr` captures the address. Repeat with `s_ready` exactly on cycle 8: no error.
- Reset asserted mid-M1 transfer: all outputs go 0 immediately; after release, a simultaneous request grants M0 first.
- `TIMEOUT`=0 with a 200-cycle slave stall: no forced ready and no `bus_err`; the normal completion happens at cycle 200.
